// File: rtl/ne_decoder_pkg.sv
// Shared LDPC decoder constants, unload FSM state encoding and the
// output-buffer beat layout.
package ne_decoder_pkg;
   localparam int Z        = 511;
   localparam int P        = 26;
   localparam int ROWDEPTH = 20;
   localparam int P_LAST   = Z - P*(ROWDEPTH-1);
   localparam int ROWWIDTH = 5;

   // Lanes 0..P_LAST-1 carry valid sign bits on the final row.
   localparam logic [P-1:0] LAST_MASK = {{(P-P_LAST){1'b0}}, {P_LAST{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } un_state_t;

   typedef struct packed {
      logic         last;
      logic [P-1:0] data;
   } un_beat_t;
endpackage

// File: rtl/ne_skid_fifo2.sv
// Two-entry register FIFO with the head entry exposed directly; it absorbs
// downstream backpressure against the one-cycle L-memory read latency.
module ne_skid_fifo2
   import ne_decoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  un_beat_t   din,
   input  logic       pop,
   output un_beat_t   head,
   output logic [1:0] occupancy
);
   un_beat_t   ent0, ent1;
   logic [1:0] occ;

   // ent0 is always the head; ent1 only holds data when two beats are queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent0 <= '0;
         ent1 <= '0;
         occ  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) ent0 <= din;
               else             ent1 <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) ent0 <= din;
               else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head      = ent0;
   assign occupancy = occ;
endmodule

// File: rtl/ne_unload_fsm.sv
// Unload controller: reads ROWDEPTH rows of hard-decision signs from the
// L memory and streams them out over valid/ready, one row per beat.
module ne_unload_fsm
   import ne_decoder_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                unload_start,
   output logic                rd_L_un,
   output logic [ROWWIDTH-1:0] rowaddress_un,
   input  logic [P-1:0]        lmem_sign,
   output logic [P-1:0]        dout,
   output logic [P-1:0]        dout_mask,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic                dout_last,
   output logic                busy,
   output logic                done,
   output logic                overrun
);
   localparam logic [ROWWIDTH-1:0] LAST_ROW = ROWWIDTH'(ROWDEPTH-1);

   un_state_t           state_q, state_d;
   logic [ROWWIDTH-1:0] row_q, addr_q;
   logic                inflight_q, inflight_last_q;
   logic                done_q, overrun_q;
   logic                issue, hs;
   logic [1:0]          occ;
   un_beat_t            head, push_beat;

   assign hs = dout_valid && dout_ready;

   // occupancy + inflight never exceeds 2, so a read is safe whenever the
   // sum is below 2 or a beat leaves the buffer this cycle.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE:  if (unload_start) state_d = READ;
         READ: begin
            issue = (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2) || hs;
            if (issue && row_q == LAST_ROW) state_d = DRAIN;
         end
         DRAIN: if (hs && head.last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         row_q           <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (row_q == LAST_ROW);
         done_q          <= (state_q == DRAIN) && hs && head.last;
         if (state_q == IDLE && unload_start) row_q <= '0;
         else if (issue)                      row_q <= row_q + 1'b1;
         if (issue) addr_q <= row_q;
         if (unload_start && state_q != IDLE) overrun_q <= 1'b1;
      end
   end

   assign push_beat = '{last: inflight_last_q, data: lmem_sign};

   ne_skid_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .din       (push_beat),
      .pop       (hs),
      .head      (head),
      .occupancy (occ)
   );

   assign rd_L_un       = issue;
   assign rowaddress_un = issue ? row_q : addr_q;
   assign dout_valid    = (occ != 2'd0);
   assign dout_mask     = dout_valid ? (head.last ? LAST_MASK : '1) : '0;
   assign dout          = head.data & dout_mask;
   assign dout_last     = dout_valid && head.last;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign overrun       = overrun_q;
endmodule

// File: tb/tb_ne_unload_fsm.sv
// Directed bench for ne_unload_fsm: a small L-memory model answers reads one
// cycle later; every beat is checked against the expected row sequence.
module tb_ne_unload_fsm;
   import ne_decoder_pkg::*;

   logic                clk = 1'b0;
   logic                rst, unload_start, rd_L_un, dout_ready;
   logic                dout_valid, dout_last, busy, done, overrun;
   logic [ROWWIDTH-1:0] rowaddress_un;
   logic [P-1:0]        lmem_sign, dout, dout_mask;

   always #5 clk = ~clk;

   ne_unload_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .unload_start  (unload_start),
      .rd_L_un       (rd_L_un),
      .rowaddress_un (rowaddress_un),
      .lmem_sign     (lmem_sign),
      .dout          (dout),
      .dout_mask     (dout_mask),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .dout_last     (dout_last),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   int n_chk, n_pass, cyc, t0, t_pre;
   int exp_row, nreads, nbeats, first_v, last_rel, done_rel;
   int max_out, stall_hold, reads_at12, valid_cnt;
   logic rd1, busy1, done_seen, rd_s;
   logic [ROWWIDTH-1:0] addr_s;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Row index replicated across the lanes.
   function automatic logic [P-1:0] pat(input int r);
      logic [29:0] t;
      t = {6{r[4:0]}};
      return t[P-1:0];
   endfunction

   function automatic logic [P-1:0] msk(input int r);
      return (r == ROWDEPTH-1) ? 26'h001FFFF : 26'h3FFFFFF;
   endfunction

   task automatic frame_clear();
      exp_row = 0; nreads = 0; nbeats = 0; first_v = 0; last_rel = 0;
      done_rel = 0; max_out = 0; stall_hold = 0; reads_at12 = -1;
      valid_cnt = 0; rd1 = 1'b0; busy1 = 1'b0; done_seen = 1'b0;
   endtask

   // Sample mid-cycle, then answer the memory read just after the edge.
   task automatic tick();
      int rel;
      @(negedge clk);
      rel = cyc - t0 + 1;
      if (nreads - nbeats > max_out) max_out = nreads - nbeats;
      if (rel == 1) begin rd1 = rd_L_un; busy1 = busy; end
      if (rd_L_un === 1'b1) begin
         chk("rd_addr", 32'(rowaddress_un), nreads);
         nreads++;
      end
      if (dout_valid === 1'b1) begin
         valid_cnt++;
         if (first_v == 0) first_v = rel;
         if (!dout_ready && exp_row == 0 && dout === pat(0)) stall_hold++;
      end
      if (rel == 12) reads_at12 = nreads;
      if (dout_valid === 1'b1 && dout_ready) begin
         chk("beat_data", 32'(dout), 32'(pat(exp_row) & msk(exp_row)));
         chk("beat_mask", 32'(dout_mask), 32'(msk(exp_row)));
         chk("beat_last", 32'(dout_last), 32'(exp_row == ROWDEPTH-1));
         if (dout_last) last_rel = rel;
         exp_row++;
         nbeats++;
      end
      if (done === 1'b1) begin done_seen = 1'b1; done_rel = rel; end
      rd_s   = rd_L_un;
      addr_s = rowaddress_un;
      @(posedge clk);
      cyc++;
      #1;
      lmem_sign = (rd_s === 1'b1) ? pat(int'(addr_s)) : ~pat(int'(addr_s));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_rd"},    32'(rd_L_un), 0);
      chk({tag, "_addr"},  32'(rowaddress_un), 0);
      chk({tag, "_dout"},  32'(dout), 0);
      chk({tag, "_mask"},  32'(dout_mask), 0);
      chk({tag, "_valid"}, 32'(dout_valid), 0);
      chk({tag, "_last"},  32'(dout_last), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_ovr"},   32'(overrun), 0);
   endtask

   // mode 0: ready high; 1: ready low in cycles 3..12; 2: random ready.
   task automatic run_frame(input int mode, input int ovr_rel, input bit chain,
                            input bit prestarted, input int tp);
      int rel;
      frame_clear();
      if (!prestarted) begin
         t0 = cyc + 1;
         unload_start = 1'b1;
         dout_ready   = 1'b1;
         tick();
         unload_start = 1'b0;
         t0 = cyc;
      end else t0 = tp;
      for (int k = 0; k < 200 && !done_seen; k++) begin
         rel = cyc - t0 + 1;
         case (mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = !(rel >= 3 && rel <= 12);
            default: dout_ready = 1'($urandom_range(0, 1));
         endcase
         unload_start = (rel == ovr_rel) || (chain && rel == 23);
         tick();
      end
      unload_start = 1'b0;
      chk("done_seen", 32'(done_seen), 1);
      chk("nbeats", nbeats, ROWDEPTH);
      chk("nreads", nreads, ROWDEPTH);
      chk("outstanding_le2", 32'(max_out <= 2), 1);
      chk("rd_row0_cycle1", 32'(rd1), 1);
      chk("busy_cycle1", 32'(busy1), 1);
   endtask

   task automatic timing_chk(input string tag);
      chk({tag, "_first_valid"}, first_v, 3);
      chk({tag, "_last_cycle"}, last_rel, 22);
      chk({tag, "_done_cycle"}, done_rel, 23);
   endtask

   initial begin
      rst = 1'b1; unload_start = 1'b0; dout_ready = 1'b0; lmem_sign = '0;
      cyc = 0; t0 = 0; n_chk = 0; n_pass = 0;
      frame_clear();
      repeat (2) tick();
      rst = 1'b0;
      check_idle("reset");

      run_frame(0, 0, 1'b0, 1'b0, 0);
      timing_chk("f1");
      chk("f1_busy_after", 32'(busy), 0);
      chk("f1_done_after", 32'(done), 0);
      chk("f1_no_overrun", 32'(overrun), 0);

      run_frame(0, 10, 1'b0, 1'b0, 0);
      timing_chk("ovr");
      chk("overrun_set", 32'(overrun), 1);

      run_frame(0, 0, 1'b1, 1'b0, 0);
      timing_chk("chainA");
      t_pre = cyc;
      run_frame(0, 0, 1'b0, 1'b1, t_pre);
      timing_chk("chainB");
      chk("overrun_sticky", 32'(overrun), 1);

      run_frame(1, 0, 1'b0, 1'b0, 0);
      chk("stall_reads", reads_at12, 2);
      chk("stall_hold_row0", stall_hold, 10);

      run_frame(2, 0, 1'b0, 1'b0, 0);

      frame_clear();
      t0 = cyc + 1;
      unload_start = 1'b1;
      dout_ready   = 1'b1;
      tick();
      unload_start = 1'b0;
      t0 = cyc;
      while (cyc - t0 + 1 < 8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_mid");
      frame_clear();
      t0 = cyc + 1000;
      repeat (6) tick();
      chk("no_stale_valid", valid_cnt, 0);
      chk("no_read_after_rst", nreads, 0);
      run_frame(0, 0, 1'b0, 1'b0, 0);
      timing_chk("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ne_unload_fsm.md
# ne_unload_fsm

Output-side unload controller for the layered LDPC decoder. It is triggered by the single-cycle `unload_start` pulse that the address generator emits when decoding completes. It then reads the ROWDEPTH rows of hard-decision sign bits out of the L memory and streams them, one P-lane row per beat, to the output interface over a valid/ready handshake. A 2-entry output buffer absorbs downstream backpressure against the fixed 1-cycle memory read latency.

## Interface
- `Z`, 511: code block size (sign bits per frame).
- `P`, 26: lanes per L-memory row.
- `ROWDEPTH`, 20: rows per frame.
- `P_LAST`, 17: valid lanes in row ROWDEPTH-1, equal to Z-P*(ROWDEPTH-1).
- `ROWWIDTH`, 5: row address width.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `unload_start`  in  1  single-cycle start pulse from address generator.
- `rd_L_un`  out  1  L-memory read enable for the unload port.
- `rowaddress_un`  out  ROWWIDTH  L-memory row being read.
- `lmem_sign`  in  P  sign bits for the row read in the previous cycle.
- `dout`  out  P  hard-decision row; lanes at or above P_LAST are forced 0 on the last row.
- `dout_mask`  out  P  valid-lane mask; all ones, except {P-P_LAST zeros, P_LAST ones} on the last row.
- `dout_valid`  out  1  beat available.
- `dout_ready`  in  1  downstream accepts beat.
- `dout_last`  out  1  beat is row ROWDEPTH-1.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse after the last handshake.
- `overrun`  out  1  sticky; set when `unload_start` arrives while busy; cleared only by `rst`.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - `unload_start=1` leads to READ, row counter 0, busy=1.
  - Otherwise stay in IDLE.
- READ:
  - Issue a read (`rd_L_un=1`, `rowaddress_un`=row counter) when credit>0 or a handshake (`dout_valid&&dout_ready`) occurs this cycle.
  - credit = 2 - occupancy - inflight.
  - Each issue increments the row counter.
  - After issuing row ROWDEPTH-1, go to DRAIN. The counter does not wrap.
- inflight: 1-bit register set on issue. `lmem_sign` is written into the FIFO in the cycle after issue, tagged last when the issued row was ROWDEPTH-1.
- DRAIN: stay until the last-tagged beat handshakes. Then go to IDLE, with busy=0 and done=1 on the next cycle.
- `unload_start` in READ or DRAIN is ignored for data and sets `overrun`.
- `unload_start` in the same cycle as `done` is accepted, because the state is already IDLE.
- When `rd_L_un=0`, `rowaddress_un` holds its last value.
- FIFO: simultaneous push and pop allowed. Pop occurs only on handshake. Overflow is impossible by the credit rule.
- `dout`/`dout_last`/`dout_mask` are stable while `dout_valid=1 && dout_ready=0`.

## Timing
- Reset values: `rd_L_un`=0, `rowaddress_un`=0, `dout`=0, `dout_mask`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0, `overrun`=0; state IDLE, FIFO empty, inflight=0.
- Cycle numbering: `unload_start` is sampled at edge E0. Cycle 1 is the cycle after E0.
- Latency with `dout_ready` held at 1:
  - Cycle 1: busy=1, read row 0.
  - Cycle 3: first `dout_valid`.
  - Cycles 3..22: one row per cycle.
  - Cycle 22: `dout_last`.
  - Cycle 23: done=1, busy=0.
- Throughput: 1 row/cycle sustained with `dout_ready=1`. With `dout_ready=0`, at most 2 rows are buffered and reads stall.
- `rst` mid-operation: next cycle all outputs return to reset values. The in-flight read is discarded and the FIFO is flushed. `lmem_sign` is not captured in the cycle after `rst`.

## Structure
- Shared package `ne_decoder_pkg`: Z, P, ROWDEPTH, P_LAST, ROWWIDTH, and the unload state encoding (IDLE=0, READ=1, DRAIN=2, 2-bit).
- Sub-module `ne_skid_fifo2`:
  - 2-entry register FIFO, width P+1 (data plus last tag).
  - push/pop/occupancy ports.
  - Output taken straight from the head register.
- `dout_mask` and the masking of `dout` are derived combinationally from the head last tag.

## Test plan
- Ready always high; `lmem_sign` = row index replicated. Expect:
  - `dout_valid` cycles 3..22 with rows 0..19 in order.
  - Row 19: `dout_mask`=0x1FFFF, lanes 17..25 = 0, `dout_last`=1.
  - `done` cycle 23.
- Ready low cycles 3..12, then high. Expect:
  - Exactly 2 reads issued before the stall (rows 0 and 1).
  - Row 0 held stable 10 cycles.
  - All 20 rows delivered once, no duplicates or drops.
- Random 50% `dout_ready`. Expect:
  - Delivered sequence rows 0..19 exactly.
  - `rd_L_un` count = 20.
  - Never more than 2 rows outstanding.
- Second `unload_start` at cycle 10 of a frame. Expect the frame to be unaffected and `overrun`=1 until `rst`. A start coincident with `done` launches a new frame, with row 0 read the next cycle.
- `rst` in cycle 8 mid-frame with a read in flight. Expect all outputs at reset values next cycle, no stale beat afterwards, and a subsequent start producing a clean full frame.
